// File: rtl/lif_neuron_array_if.sv
// Memory-mapped register port between the core and the LIF neuron array.
// Read data is registered in the slave and is valid one clock after the read strobe.
interface lif_neuron_array_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic                  risc_v_read;
    logic                  risc_v_write;
    logic [ADDR_WIDTH-1:0] risc_v_addr;
    logic [DATA_WIDTH-1:0] risc_v_data_in;
    logic [DATA_WIDTH-1:0] risc_v_data_out;

    modport master (
        output risc_v_read, risc_v_write, risc_v_addr, risc_v_data_in,
        input  risc_v_data_out
    );

    modport slave (
        input  risc_v_read, risc_v_write, risc_v_addr, risc_v_data_in,
        output risc_v_data_out
    );
endinterface

// File: rtl/lif_neuron_array.sv
// Leaky integrate-and-fire neuron array: a STEP write sweeps one neuron per cycle, busy for N+1 cycles.
// LIF_REFRACTORY_EN builds per-neuron refractory counters; STEP writes while busy are dropped and flag overrun.
module lif_neuron_array #(
    parameter int NUM_NEURONS    = 4,
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 16,
    parameter int THRESHOLD      = 1000,
    parameter int LEAK_SHIFT     = 4,
    parameter int REFRACT_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    lif_neuron_array_if.slave      bus,
    output logic [NUM_NEURONS-1:0] spike_vector,
    output logic                   spike_detected,
    output logic                   busy
);
    localparam int AW   = ADDR_WIDTH;
    localparam int DW   = DATA_WIDTH;
    localparam int IDXW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    localparam logic [AW-1:0]   A_STEP   = AW'('h20);
    localparam logic [AW-1:0]   A_THRESH = AW'('h21);
    localparam logic [AW-1:0]   A_STATUS = AW'('h22);
    localparam logic [AW-1:0]   A_SPIKES = AW'('h23);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_NEURONS - 1);

    localparam logic signed [DW+1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
    state_t state, state_nxt;

    logic        [DW-1:0]          weight [NUM_NEURONS];
    logic signed [DW-1:0]          pot    [NUM_NEURONS];
    logic signed [DW-1:0]          thresh;
    logic        [IDXW-1:0]        idx;
    logic        [NUM_NEURONS-1:0] mask;
    logic        [NUM_NEURONS-1:0] spike_acc;
    logic                          overrun;

    logic                          wr_en;
    logic                          step_wr;
    logic                          step_go;
    logic        [DW-1:0]          rd_dat;

    logic signed [DW+1:0]          ext_v, ext_w, leak, sum;
    logic signed [DW-1:0]          nxt_v;
    logic                          fire;
    logic                          in_refract;

`ifdef LIF_REFRACTORY_EN
    localparam int RW = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
    logic [RW-1:0] refract [NUM_NEURONS];
    assign in_refract = (refract[idx] != '0);
`else
    assign in_refract = 1'b0;
`endif

    assign wr_en   = bus.risc_v_write;
    assign step_wr = wr_en && (bus.risc_v_addr == A_STEP);
    assign step_go = step_wr && (state == IDLE);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (step_wr) state_nxt = SWEEP;
            SWEEP:   if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Wide arithmetic so the leak and weight add cannot wrap before saturation.
    always_comb begin
        ext_v = {{2{pot[idx][DW-1]}}, pot[idx]};
        ext_w = mask[idx] ? {{2{weight[idx][DW-1]}}, weight[idx]} : '0;
        leak  = ext_v >>> LEAK_SHIFT;
        sum   = ext_v - leak + ext_w;
        if (sum > SAT_MAX)      nxt_v = SAT_MAX[DW-1:0];
        else if (sum < SAT_MIN) nxt_v = SAT_MIN[DW-1:0];
        else                    nxt_v = sum[DW-1:0];
        fire = (nxt_v >= thresh);
    end

    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (bus.risc_v_addr == AW'(i))      rd_dat = weight[i];
            if (bus.risc_v_addr == AW'(16 + i)) rd_dat = pot[i];
        end
        if (bus.risc_v_addr == A_THRESH) rd_dat = thresh;
        if (bus.risc_v_addr == A_STATUS) rd_dat = DW'({overrun, busy});
        if (bus.risc_v_addr == A_SPIKES) rd_dat = DW'(spike_vector);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                weight[i]  <= '0;
                pot[i]     <= '0;
`ifdef LIF_REFRACTORY_EN
                refract[i] <= '0;
`endif
            end
            thresh              <= DW'(THRESHOLD);
            idx                 <= '0;
            mask                <= '0;
            spike_acc           <= '0;
            spike_vector        <= '0;
            spike_detected      <= 1'b0;
            overrun             <= 1'b0;
            bus.risc_v_data_out <= '0;
        end else begin
            if (bus.risc_v_read) bus.risc_v_data_out <= rd_dat;

            if (wr_en) begin
                for (int i = 0; i < NUM_NEURONS; i++) begin
                    if (bus.risc_v_addr == AW'(i)) weight[i] <= bus.risc_v_data_in;
                    if (bus.risc_v_addr == AW'(16 + i) && !busy) pot[i] <= bus.risc_v_data_in;
                end
                if (bus.risc_v_addr == A_THRESH) thresh <= bus.risc_v_data_in;
                if (bus.risc_v_addr == A_STATUS && bus.risc_v_data_in[1]) overrun <= 1'b0;
            end

            if (step_wr && busy) overrun <= 1'b1;

            if (step_go) begin
                mask      <= bus.risc_v_data_in[NUM_NEURONS-1:0];
                idx       <= '0;
                spike_acc <= '0;
            end

            if (state == SWEEP) begin
                if (in_refract) begin
`ifdef LIF_REFRACTORY_EN
                    refract[idx] <= refract[idx] - 1'b1;
`endif
                    pot[idx] <= '0;
                end else if (fire) begin
                    spike_acc[idx] <= 1'b1;
                    pot[idx]       <= '0;
`ifdef LIF_REFRACTORY_EN
                    refract[idx]   <= RW'(REFRACT_CYCLES);
`endif
                end else begin
                    pot[idx] <= nxt_v;
                end
                if (idx != LAST_IDX) idx <= idx + 1'b1;
            end

            if (state == DONE) begin
                spike_vector   <= spike_acc;
                spike_detected <= |spike_acc;
            end
        end
    end
endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed register-level bench for lif_neuron_array with hand-computed expectations.
module tb_lif_neuron_array;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] spike_vector;
    logic         spike_detected;
    logic         busy;

    int n_chk  = 0;
    int n_pass = 0;

    lif_neuron_array_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus ();

    lif_neuron_array #(
        .NUM_NEURONS(N), .ADDR_WIDTH(6), .DATA_WIDTH(16),
        .THRESHOLD(1000), .LEAK_SHIFT(4), .REFRACT_CYCLES(3)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .spike_vector(spike_vector), .spike_detected(spike_detected), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.risc_v_write   = 1'b1;
        bus.risc_v_addr    = a;
        bus.risc_v_data_in = d;
        @(negedge clk);
        bus.risc_v_write   = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.risc_v_read = 1'b1;
        bus.risc_v_addr = a;
        @(negedge clk);
        bus.risc_v_read = 1'b0;
        d = bus.risc_v_data_out;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 64) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic step(input logic [15:0] m, output int cycles);
        wr(6'h20, m);
        wait_idle(cycles);
    endtask

    logic [15:0] d;
    int          cyc;

    initial begin
        reset = 1'b1;
        bus.risc_v_read    = 1'b0;
        bus.risc_v_write   = 1'b0;
        bus.risc_v_addr    = '0;
        bus.risc_v_data_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset_spikes", 32'(spike_vector), 32'h0);
        check("reset_detect", 32'(spike_detected), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_dout", 32'(bus.risc_v_data_out), 32'h0);
        rd(6'h21, d); check("reset_thresh", 32'(d), 32'h03E8);
        rd(6'h22, d); check("reset_status", 32'(d), 32'h0);

        wr(6'h3F, 16'h1234);
        rd(6'h3F, d); check("unmapped_3f", 32'(d), 32'h0);
        wr(6'h05, 16'h1111);
        rd(6'h05, d); check("unmapped_w5", 32'(d), 32'h0);

        // Integrate to threshold: 600, then 600 - 37 + 600 = 1163.
        wr(6'h00, 16'd600);
        rd(6'h00, d); check("weight0", 32'(d), 32'd600);
        step(16'h1, cyc);
        check("busy_len1", 32'(cyc), 32'(N + 1));
        rd(6'h10, d); check("pot0_step1", 32'(d), 32'd600);
        check("spikes_step1", 32'(spike_vector), 32'h0);
        step(16'h1, cyc);
        check("busy_len2", 32'(cyc), 32'(N + 1));
        rd(6'h10, d); check("pot0_step2", 32'(d), 32'h0);
        check("spikes_step2", 32'(spike_vector), 32'h1);
        check("detect_step2", 32'(spike_detected), 32'h1);
        rd(6'h23, d); check("spikes_reg", 32'(d), 32'h1);

`ifdef LIF_REFRACTORY_EN
        for (int k = 0; k < 3; k++) begin
            step(16'h1, cyc);
            rd(6'h10, d); check("pot0_refract", 32'(d), 32'h0);
            check("spikes_refract", 32'(spike_vector), 32'h0);
        end
`endif
        step(16'h1, cyc);
        rd(6'h10, d); check("pot0_after", 32'(d), 32'd600);
        check("spikes_after", 32'(spike_vector), 32'h0);

        // Saturation on neuron 1; neuron 0 only leaks: 600 - 37 = 563.
        wr(6'h11, 16'h8000);
        wr(6'h01, 16'h8000);
        step(16'h2, cyc);
        rd(6'h11, d); check("pot1_sat", 32'(d), 32'h8000);
        rd(6'h10, d); check("pot0_leak", 32'(d), 32'd563);
        check("spikes_sat", 32'(spike_vector), 32'h0);

        // Back-to-back STEP: second is dropped and flags overrun. Neuron 0: 563 - 35 = 528.
        @(negedge clk);
        bus.risc_v_write   = 1'b1;
        bus.risc_v_addr    = 6'h20;
        bus.risc_v_data_in = 16'h0;
        @(negedge clk);
        @(negedge clk);
        bus.risc_v_write   = 1'b0;
        rd(6'h22, d); check("status_mid", 32'(d), 32'h3);
        wait_idle(cyc);
        check("overrun_timeout", 32'(busy), 32'h0);
        rd(6'h22, d); check("status_after", 32'(d), 32'h2);
        wr(6'h22, 16'h2);
        rd(6'h22, d); check("status_clear", 32'(d), 32'h0);
        rd(6'h10, d); check("pot0_overrun", 32'(d), 32'd528);

        // Read and write of THRESH on the same cycle returns the old value.
        @(negedge clk);
        bus.risc_v_read    = 1'b1;
        bus.risc_v_write   = 1'b1;
        bus.risc_v_addr    = 6'h21;
        bus.risc_v_data_in = 16'd500;
        @(negedge clk);
        bus.risc_v_read    = 1'b0;
        bus.risc_v_write   = 1'b0;
        check("rw_old", 32'(bus.risc_v_data_out), 32'd1000);
        rd(6'h21, d); check("thresh_new", 32'(d), 32'd500);

        // 528 - 33 + 600 = 1095 >= 500 fires neuron 0.
        step(16'h1, cyc);
        check("spikes_thr500", 32'(spike_vector), 32'h1);
        rd(6'h10, d); check("pot0_thr500", 32'(d), 32'h0);

        // Reset sampled at E0+2 of a sweep.
        wr(6'h12, 16'd77);
        @(negedge clk);
        bus.risc_v_write   = 1'b1;
        bus.risc_v_addr    = 6'h20;
        bus.risc_v_data_in = 16'hF;
        @(negedge clk);
        bus.risc_v_write   = 1'b0;
        check("busy_started", 32'(busy), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_spikes", 32'(spike_vector), 32'h0);
        check("rst_detect", 32'(spike_detected), 32'h0);
        for (int i = 0; i < N; i++) begin
            rd(6'(16 + i), d); check("rst_pot", 32'(d), 32'h0);
        end
        rd(6'h21, d); check("rst_thresh", 32'(d), 32'd1000);
        rd(6'h01, d); check("rst_weight1", 32'(d), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
